// File: rtl/add_and_or_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_and_or_unit_pkg
// Brief    : Op encodings and NZCV flag bit indices shared with ALU decode.
// Revision : 1.0 - initial release
// ============================================================================
package add_and_or_unit_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/add_and_or_unit_aol_core.sv
`default_nettype none
// ============================================================================
// Module   : aol_core
// Brief    : Combinational adder / AND / OR arrays, op mux and NZCV generation.
// Revision : 1.0 - initial release
// ============================================================================
module aol_core
    import add_and_or_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic             w_ovf;

    assign w_sum = {1'b0, in1} + {1'b0, in2};
    assign w_and = in1 & in2;
    assign w_or  = in1 | in2;
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign w_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);

    always_comb begin
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                result         = w_sum[WIDTH-1:0];
                flags[FLAG_C]  = w_sum[WIDTH];
                flags[FLAG_V]  = w_ovf;
            end
            OP_AND:  result = w_and;
            OP_OR:   result = w_or;
            default: result = '0;
        endcase
        // Reserved op leaves Z clear even though its result is zero.
        if (op != OP_RSVD) begin
            flags[FLAG_N] = result[WIDTH-1];
            flags[FLAG_Z] = (result == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_and_or_unit.sv
`default_nettype none
// ============================================================================
// Module   : add_and_or_unit
// Brief    : Registered 32-bit ADD/AND/OR unit with NZCV flags, 1-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module add_and_or_unit
    import add_and_or_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_out_valid;

    aol_core #(
        .WIDTH (WIDTH)
    ) u_aol_core (
        .op     (op),
        .in1    (in1),
        .in2    (in2),
        .result (w_result),
        .flags  (w_flags)
    );

    // Result and flags only load on valid cycles so they hold across idle gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_add_and_or_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_and_or_unit
// Brief    : Directed self-checking bench for add_and_or_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_and_or_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    add_and_or_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        op       = o;
        in1      = a;
        in2      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] r, input logic [3:0] f, input logic v);
        check({tag, "_result"}, result, r);
        check({tag, "_flags"}, {28'd0, flags}, {28'd0, f});
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    endtask

    initial begin
        reset = 1'b1;
        step(1'b0, 2'b00, 32'd0, 32'd0);
        step(1'b0, 2'b00, 32'd0, 32'd0);
        expect_out("reset_state", 32'd0, 4'b0000, 1'b0);
        reset = 1'b0;

        step(1'b1, 2'b00, 32'd5, 32'd7);
        expect_out("add_basic", 32'd12, 4'b0000, 1'b1);
        step(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd1);
        expect_out("add_carry_zero", 32'd0, 4'b0110, 1'b1);
        step(1'b1, 2'b00, 32'h7FFF_FFFF, 32'd1);
        expect_out("add_ovf", 32'h8000_0000, 4'b1001, 1'b1);
        step(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000);
        expect_out("add_neg_ovf", 32'd0, 4'b0111, 1'b1);

        step(1'b1, 2'b01, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        expect_out("and", 32'h00F0_00F0, 4'b0000, 1'b1);
        step(1'b1, 2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        expect_out("or", 32'hFFF0_FFF0, 4'b1000, 1'b1);
        step(1'b0, 2'b01, 32'd0, 32'd0);
        expect_out("hold_flags", 32'hFFF0_FFF0, 4'b1000, 1'b0);
        step(1'b1, 2'b01, 32'hAAAA_AAAA, 32'h5555_5555);
        expect_out("and_zero", 32'd0, 4'b0100, 1'b1);

        step(1'b1, 2'b00, 32'd1, 32'd2);
        expect_out("add_1_2", 32'd3, 4'b0000, 1'b1);
        step(1'b0, 2'b00, 32'd10, 32'd20);
        expect_out("invalid_hold", 32'd3, 4'b0000, 1'b0);
        step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'd1);
        expect_out("reserved", 32'd0, 4'b0000, 1'b1);

        step(1'b1, 2'b00, 32'd9, 32'd9);
        reset = 1'b1;
        step(1'b1, 2'b00, 32'd3, 32'd4);
        expect_out("reset_priority", 32'd0, 4'b0000, 1'b0);
        reset = 1'b0;
        step(1'b1, 2'b00, 32'd3, 32'd4);
        expect_out("after_reset", 32'd7, 4'b0000, 1'b1);

        step(1'b1, 2'b00, 32'd10, 32'd20);
        expect_out("b2b_add", 32'd30, 4'b0000, 1'b1);
        step(1'b1, 2'b01, 32'h0000_00FF, 32'h0000_000F);
        expect_out("b2b_and", 32'h0000_000F, 4'b0000, 1'b1);
        step(1'b1, 2'b10, 32'h0000_00F0, 32'h0000_000F);
        expect_out("b2b_or", 32'h0000_00FF, 4'b0000, 1'b1);
        // Inputs changing between edges must not reach the outputs.
        in1 = 32'hDEAD_BEEF;
        #2;
        check("no_comb_path", result, 32'h0000_00FF);
        step(1'b0, 2'b00, 32'd0, 32'd0);
        expect_out("b2b_idle", 32'h0000_00FF, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
